// File: rtl/ab_sequencer.sv
// Operand sequencer: shows {a,b} for SHOW_TICKS ticks, then a-b or Gray({a,b}) for RES_TICKS ticks.
// Optional abort input is enabled by defining AB_SEQ_ABORT_EN.
module ab_sequencer #(
    parameter int W          = 4,
    parameter int CNT_W      = 8,
    parameter int SHOW_TICKS = 6,
    parameter int RES_TICKS  = 3
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [1:0]     mode,
    input  logic           tick,
`ifdef AB_SEQ_ABORT_EN
    input  logic           abort,
`endif
    output logic           busy,
    output logic           done,
    output logic [1:0]     state,
    output logic [2*W-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SHOW = 2'b01,
        SUB  = 2'b10,
        GRAY = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_TICKS - 1);
    localparam logic [CNT_W-1:0] RES_LAST  = CNT_W'(RES_TICKS - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] count_reg;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [1:0]       mode_reg;
    logic [2*W-1:0]   result_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [2*W-1:0]   ab_cat;
    logic [2*W-1:0]   diff_val;
    logic [2*W-1:0]   gray_val;
    logic             abort_req;
    logic             phase_last;

    assign ab_cat   = {a_reg, b_reg};
    assign diff_val = {{W{1'b0}}, a_reg} - {{W{1'b0}}, b_reg};

    // Gray code: MSB passes through, every other bit is XOR with its upper neighbour
    assign gray_val[2*W-1] = ab_cat[2*W-1];
    generate
        for (genvar gi = 0; gi < 2*W-1; gi++) begin : g_gray
            assign gray_val[gi] = ab_cat[gi+1] ^ ab_cat[gi];
        end
    endgenerate

`ifdef AB_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign phase_last = (state_reg == SHOW) ? (count_reg == SHOW_LAST)
                                            : (count_reg == RES_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            mode_reg   <= '0;
            result_reg <= '1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (state_reg == IDLE) begin
                if (start) begin
                    a_reg      <= a;
                    b_reg      <= b;
                    mode_reg   <= mode;
                    state_reg  <= SHOW;
                    result_reg <= {a, b};
                    count_reg  <= '0;
                    busy_reg   <= 1'b1;
                end
            end else if (abort_req) begin
                state_reg  <= IDLE;
                result_reg <= '1;
                count_reg  <= '0;
                busy_reg   <= 1'b0;
            end else if (tick) begin
                if (!phase_last) begin
                    count_reg <= count_reg + CNT_W'(1);
                end else begin
                    count_reg <= '0;
                    if (state_reg == SHOW) begin
                        case (mode_reg)
                            2'b00: begin
                                if (a_reg > b_reg) begin
                                    state_reg  <= SUB;
                                    result_reg <= diff_val;
                                end else begin
                                    state_reg  <= GRAY;
                                    result_reg <= gray_val;
                                end
                            end
                            2'b01: begin
                                state_reg  <= SUB;
                                result_reg <= diff_val;
                            end
                            2'b10: begin
                                state_reg  <= GRAY;
                                result_reg <= gray_val;
                            end
                            default: begin
                                state_reg  <= IDLE;
                                result_reg <= '1;
                                busy_reg   <= 1'b0;
                                done_reg   <= 1'b1;
                            end
                        endcase
                    end else begin
                        state_reg  <= IDLE;
                        result_reg <= '1;
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                    end
                end
            end
        end
    end

    assign state  = state_reg;
    assign result = result_reg;
    assign busy   = busy_reg;
    assign done   = done_reg;

endmodule

// File: tb/tb_ab_sequencer.sv
// Bench for ab_sequencer: segment-queue reference model checked every cycle plus directed literal checks.
module tb_ab_sequencer;

    localparam int W          = 4;
    localparam int SHOW_TICKS = 6;
    localparam int RES_TICKS  = 3;

    logic         clock;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   mode;
    logic         tick;
`ifdef AB_SEQ_ABORT_EN
    logic         abort;
`endif
    logic         busy;
    logic         done;
    logic [1:0]   state;
    logic [7:0]   result;

    int n_pass  = 0;
    int n_total = 0;

    ab_sequencer #(.W(W), .CNT_W(8), .SHOW_TICKS(SHOW_TICKS), .RES_TICKS(RES_TICKS)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .mode   (mode),
        .tick   (tick),
`ifdef AB_SEQ_ABORT_EN
        .abort  (abort),
`endif
        .busy   (busy),
        .done   (done),
        .state  (state),
        .result (result)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: a run is a queue of display segments, each lasting a number of ticks
    typedef struct {
        logic [1:0] st;
        logic [7:0] res;
        int         ticks;
    } seg_t;

    seg_t segq[$];
    int   m_cnt   = 0;
    logic m_done  = 1'b0;
    bit   m_valid = 1'b0;

    always @(posedge clock) begin
        seg_t s;
        logic [7:0] cat;
        if (reset) begin
            segq.delete();
            m_cnt   = 0;
            m_done  = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_done = 1'b0;
            if (segq.size() == 0) begin
                if (start) begin
                    cat     = {a, b};
                    s.st    = 2'b01;
                    s.res   = cat;
                    s.ticks = SHOW_TICKS;
                    segq.push_back(s);
                    s.ticks = RES_TICKS;
                    if (mode == 2'b01 || (mode == 2'b00 && int'(a) > int'(b))) begin
                        s.st  = 2'b10;
                        s.res = 8'((int'(a) - int'(b) + 256) % 256);
                        segq.push_back(s);
                    end else if (mode != 2'b11) begin
                        s.st  = 2'b11;
                        s.res = cat ^ (cat >> 1);
                        segq.push_back(s);
                    end
                    m_cnt = 0;
                end
            end
`ifdef AB_SEQ_ABORT_EN
            else if (abort) begin
                segq.delete();
                m_cnt = 0;
            end
`endif
            else if (tick) begin
                m_cnt++;
                if (m_cnt == segq[0].ticks) begin
                    segq.delete(0);
                    m_cnt = 0;
                    if (segq.size() == 0) m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin
        logic [1:0] e_st;
        logic [7:0] e_res;
        logic       e_busy;
        if (m_valid) begin
            e_st   = (segq.size() != 0) ? segq[0].st : 2'b00;
            e_res  = (segq.size() != 0) ? segq[0].res : 8'hFF;
            e_busy = (segq.size() != 0);
            n_total++;
            if (state === e_st && result === e_res && busy === e_busy && done === m_done)
                n_pass++;
            else
                $display("FAIL model t=%0t: got state=%0d result=%h busy=%b done=%b, required state=%0d result=%h busy=%b done=%b",
                         $time, state, result, busy, done, e_st, e_res, e_busy, m_done);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Starts a run (start is raised at the current negedge) and measures it until done or timeout
    task automatic run(input logic [3:0] ra, input logic [3:0] rb, input logic [1:0] rm,
                       input int period, input bit perturb,
                       output int show_n, output int res_n, output int busy_n,
                       output int show_val, output int res_val, output int res_st, output bit got_done);
        show_n = 0; res_n = 0; busy_n = 0;
        show_val = -1; res_val = -1; res_st = 0; got_done = 1'b0;
        a = ra; b = rb; mode = rm; start = 1'b1; tick = (period == 1);
        @(negedge clock);
        start = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            if (state == 2'b01) begin
                show_n++;
                if (show_n == 1) show_val = int'(result);
            end else if (state[1]) begin
                res_n++;
                if (res_n == 1) begin
                    res_val = int'(result);
                    res_st  = int'(state);
                end
            end
            if (busy) busy_n++;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            tick = (period == 1) || (k % period == 0);
            if (perturb && k == 5) begin
                a = ~ra; b = ~rb; mode = ~rm; start = 1'b1;
            end
            if (perturb && k == 6) start = 1'b0;
            @(negedge clock);
        end
    endtask

    task automatic do_run(input string nm, input logic [3:0] ra, input logic [3:0] rb,
                          input logic [1:0] rm, input int period, input bit perturb,
                          input int e_show, input int e_res, input int e_sv, input int e_rv, input int e_rst);
        int show_n, res_n, busy_n, show_val, res_val, res_st;
        bit got_done;
        run(ra, rb, rm, period, perturb, show_n, res_n, busy_n, show_val, res_val, res_st, got_done);
        chk({nm, " done_seen"}, int'(got_done), 1);
        chk({nm, " show_cycles"}, show_n, e_show);
        chk({nm, " res_cycles"}, res_n, e_res);
        chk({nm, " busy_cycles"}, busy_n, e_show + e_res);
        chk({nm, " show_value"}, show_val, e_sv);
        chk({nm, " res_value"}, res_val, e_rv);
        chk({nm, " res_state"}, res_st, e_rst);
        $display("run %s a=%0h b=%0h mode=%0d: show=%0d res=%0d busy=%0d sv=%0h rv=%0h rst=%0d",
                 nm, ra, rb, rm, show_n, res_n, busy_n, show_val, res_val, res_st);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; tick = 1'b0; a = '0; b = '0; mode = 2'b00;
`ifdef AB_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge clock);
        chk("reset state", int'(state), 0);
        chk("reset result", int'(result), 8'hFF);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Back-to-back runs also exercise start accepted in the done cycle
        do_run("auto_sub",       4'h9, 4'h3, 2'b00, 1, 1'b0, 6, 3, 8'h93, 8'h06, 2);
        do_run("auto_gray",      4'h3, 4'h9, 2'b00, 1, 1'b0, 6, 3, 8'h39, 8'h25, 3);
        do_run("force_sub_wrap", 4'h3, 4'h9, 2'b01, 1, 1'b0, 6, 3, 8'h39, 8'hFA, 2);
        do_run("show_only",      4'h9, 4'h3, 2'b11, 1, 1'b0, 6, 0, 8'h93, -1,    0);
        do_run("force_gray",     4'h9, 4'h3, 2'b10, 1, 1'b0, 6, 3, 8'h93, 8'hDA, 3);
        do_run("equal_auto",     4'h5, 4'h5, 2'b00, 1, 1'b0, 6, 3, 8'h55, 8'h7F, 3);
        tick = 1'b0;
        repeat (3) @(negedge clock);
        do_run("tick_gated",     4'h9, 4'h3, 2'b00, 4, 1'b1, 24, 12, 8'h93, 8'h06, 2);

        // Reset during the third SHOW cycle
        a = 4'h9; b = 4'h3; mode = 2'b00; tick = 1'b1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midreset state", int'(state), 0);
        chk("midreset result", int'(result), 8'hFF);
        chk("midreset busy", int'(busy), 0);
        chk("midreset done", int'(done), 0);
        $display("midreset: state=%0d result=%h busy=%b done=%b", state, result, busy, done);
        reset = 1'b0;
        @(negedge clock);
        do_run("after_reset",    4'hC, 4'h4, 2'b00, 1, 1'b0, 6, 3, 8'hC4, 8'h08, 2);

`ifdef AB_SEQ_ABORT_EN
        // Abort during SUB
        a = 4'h9; b = 4'h3; mode = 2'b01; tick = 1'b1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 20 && state != 2'b10; k++) @(negedge clock);
        chk("abort reached_sub", int'(state), 2);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("abort state", int'(state), 0);
        chk("abort result", int'(result), 8'hFF);
        chk("abort done", int'(done), 0);
        $display("abort in SUB: state=%0d result=%h done=%b", state, result, done);
        @(negedge clock);
        chk("abort done_later", int'(done), 0);
        // Start and abort together in IDLE: start wins
        start = 1'b1; abort = 1'b1; a = 4'h2; b = 4'h7;
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        chk("start_over_abort state", int'(state), 1);
        chk("start_over_abort result", int'(result), 8'h27);
        $display("start+abort in IDLE: state=%0d result=%h", state, result);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("abort_show state", int'(state), 0);
`endif

        tick = 1'b0;
        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
